// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8x-oversampled UART receiver with an AXI4-Stream master output.
//
// Frame format: 1 start bit (low), DATA_WIDTH data bits LSB first, 1 stop bit
// (high). One bit period is prescale*8 clk cycles; prescale is captured when
// the start edge is seen and held for the whole frame (0 behaves as 1).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   m_axis_tdata   out  received word (stable while tvalid && !tready)
//   m_axis_tvalid  out  word valid, held until accepted
//   m_axis_tready  in   downstream accept
//   rxd            in   asynchronous serial input, idle high
//   busy           out  high while a frame is being received
//   overrun_error  out  1-cycle pulse: new word replaced an unaccepted one
//   frame_error    out  1-cycle pulse: stop bit sampled low, word dropped
//   prescale       in   clocks per bit divided by 8
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample point (start, data, stop)
//                        is a 2-of-3 vote over the rxd_s samples taken at
//                        timer values 1, 0 and the cycle after 0. The decision
//                        lands one cycle later than in the single-sample build.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  // 19 bits hold prescale*8 for the largest 16-bit prescale.
  localparam int TW = 19;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state_q;
  logic                  rxd_meta_q;
  logic                  rxd_s_q;
  logic [15:0]           presc_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  busy_q;
  logic                  ovr_q;
  logic                  ferr_q;

  logic [15:0]           presc_in;
  logic [TW-1:0]         full_m1;
  logic [TW-1:0]         half_new_m1;
  logic                  samp_evt;
  logic                  samp_bit;

  function automatic logic [15:0] eff_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

  assign presc_in    = eff_prescale(prescale);
  // Mid-start reload is computed from the live input because the capture into
  // presc_q happens on the same edge the start is detected.
  assign half_new_m1 = {1'b0, presc_in, 2'b00} - TW'(1);
  assign full_m1     = {presc_q, 3'b000} - TW'(1);

  // ---------------------------------------------------------------------------
  // Sample-point decision
  // ---------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  logic s1_q;
  logic s0_q;
  logic pend_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Samples at timer 1 and 0 are stored; the third sample is the live rxd_s
  // in the following cycle, when pend_q fires the decision. The timer has
  // already reloaded at 0, so the bit period between decisions is unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      if (timer_q == TW'(1)) s1_q <= rxd_s_q;
      if (timer_q == '0)     s0_q <= rxd_s_q;
      pend_q <= (state_q != IDLE) && (timer_q == '0);
    end
  end

  assign samp_evt = pend_q;
  assign samp_bit = maj3(s1_q, s0_q, rxd_s_q);
`else
  assign samp_evt = (state_q != IDLE) && (timer_q == '0);
  assign samp_bit = rxd_s_q;
`endif

  // ---------------------------------------------------------------------------
  // Bit timer: loaded with half a bit on start detection, then free-runs in
  // full-bit periods while a frame is active. In IDLE it simply holds.
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_d = timer_q;
    if (state_q == IDLE) begin
      if (!rxd_s_q) timer_d = half_new_m1;
    end else if (timer_q == '0) begin
      timer_d = full_m1;
    end else begin
      timer_d = timer_q - TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronizer, frame FSM and stream output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= IDLE;
      presc_q    <= '0;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      timer_q    <= timer_d;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;

      // Acceptance; a word completing in the same cycle overrides below.
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            presc_q <= presc_in;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end

        START: begin
          if (samp_evt) begin
            if (samp_bit) begin
              // Glitch shorter than half a bit: drop silently.
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              bit_cnt_q <= CW'(DATA_WIDTH);
              state_q   <= DATA;
            end
          end
        end

        DATA: begin
          if (samp_evt) begin
            shreg_q   <= {samp_bit, shreg_q[DATA_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q - CW'(1);
            if (bit_cnt_q == CW'(1)) state_q <= STOP;
          end
        end

        STOP: begin
          if (samp_evt) begin
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (samp_bit) begin
              tdata_q  <= shreg_q;
              tvalid_q <= 1'b1;
              ovr_q    <= tvalid_q && !m_axis_tready;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (DATA_WIDTH = 8).
// A serial driver produces frames at prescale*8 cycles per bit; a monitor
// collects accepted words and error pulses; expectations come from a table,
// from hand-written corner sequences and from a queue of sent words.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rxd;
  logic         tready;
  logic [15:0]  prescale;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         busy;
  logic         overrun_error;
  logic         frame_error;

  uart_rx #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int fe_cyc = -1;
  int tv_cyc = -1;
  int t_start = 0;
  bit tv_prev = 1'b0;
  bit rnd_on = 1'b0;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && tready) got_q.push_back(m_axis_tdata);
      if (m_axis_tvalid && !tv_prev) tv_cyc = cyc;
      if (frame_error) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (overrun_error) ov_cnt++;
      if (busy) busy_cnt++;
    end
    tv_prev = m_axis_tvalid;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Leaves the caller at posedge+1.
  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; entered and left at posedge+1 so calls chain gap-free.
  task automatic send_frame(input int p, input logic [W-1:0] d, input bit stop_ok,
                            input bit push, input bit junk);
    int pe;
    logic [W+1:0] fr;
    pe = (p == 0) ? 1 : p;
    fr = {stop_ok, d, 1'b0};
    prescale = 16'(p);
    for (int b = 0; b < W + 2; b++) begin
      rxd = fr[b];
      if (b == 0) t_start = cyc + 1;
      if (junk && b == 1) prescale = 16'($urandom_range(0, 200));
      if (b == W + 1) prescale = 16'(p);
      repeat (8 * pe) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    if (stop_ok && push) exp_q.push_back(d);
  endtask

  task automatic check_words(input string name);
    chk({name, " word count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({name, " word"}, int'(got_q[i]), int'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " tdata"},  int'(m_axis_tdata), 0);
    chk({name, " tvalid"}, int'(m_axis_tvalid), 0);
    chk({name, " busy"},   int'(busy), 0);
    chk({name, " ferr"},   int'(frame_error), 0);
    chk({name, " ovr"},    int'(overrun_error), 0);
  endtask

  typedef struct {
    int           p;
    logic [W-1:0] data;
    bit           stop_ok;
    bit           exp_word;
    logic [W-1:0] exp_data;
    bit           exp_fe;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int fe0, ov0, nbad;

    tbl[0] = '{1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{2, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{2, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    tbl[3] = '{0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
    tbl[4] = '{3, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[5] = '{1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[6] = '{5, 8'h96, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{4, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0};

    rxd = 1'b1;
    tready = 1'b1;
    prescale = 16'd1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      int pe;
      pe = (tbl[i].p == 0) ? 1 : tbl[i].p;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      busy_cnt = 0;
      tv_cyc = -1;
      fe_cyc = -1;
      got_q.delete();
      send_frame(tbl[i].p, tbl[i].data, tbl[i].stop_ok, 1'b0, 1'b0);
      idle(tbl[i].stop_ok ? 8 * pe : 24 * pe);
      chk($sformatf("row%0d words", i), got_q.size(), int'(tbl[i].exp_word));
      if (tbl[i].exp_word && got_q.size() > 0)
        chk($sformatf("row%0d data", i), int'(got_q[0]), int'(tbl[i].exp_data));
      chk($sformatf("row%0d ferr", i), fe_cnt - fe0, int'(tbl[i].exp_fe));
      chk($sformatf("row%0d ovr", i), ov_cnt - ov0, 0);
      chk($sformatf("row%0d tvalid idle", i), int'(m_axis_tvalid), 0);
      if (tbl[i].exp_word) begin
        chk_rng($sformatf("row%0d tvalid latency", i), tv_cyc - t_start, 76 * pe + 2, 76 * pe + 3);
        chk_rng($sformatf("row%0d busy cycles", i), busy_cnt, 76 * pe, 76 * pe + 1);
      end
      if (tbl[i].exp_fe)
        chk_rng($sformatf("row%0d ferr time", i), fe_cyc - t_start, 76 * pe + 2, 76 * pe + 3);
    end

    // False start: 3 low cycles at prescale 4.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    busy_cnt = 0;
    got_q.delete();
    prescale = 16'd4;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(40);
    chk_rng("false start busy cycles", busy_cnt, 16, 17);
    chk("false start busy end", int'(busy), 0);
    chk("false start words", got_q.size(), 0);
    chk("false start ferr", fe_cnt - fe0, 0);
    chk("false start ovr", ov_cnt - ov0, 0);

    // Overrun: two back-to-back frames with tready low.
    tready = 1'b0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    got_q.delete();
    send_frame(1, 8'h11, 1'b1, 1'b0, 1'b0);
    chk("ovr first tvalid", int'(m_axis_tvalid), 1);
    chk("ovr first tdata", int'(m_axis_tdata), 'h11);
    send_frame(1, 8'h22, 1'b1, 1'b0, 1'b0);
    idle(8);
    chk("ovr pulses", ov_cnt - ov0, 1);
    chk("ovr ferr", fe_cnt - fe0, 0);
    chk("ovr tvalid held", int'(m_axis_tvalid), 1);
    chk("ovr tdata", int'(m_axis_tdata), 'h22);
    chk("ovr no accept", got_q.size(), 0);
    tready = 1'b1;
    @(negedge clk);
    chk("ovr tvalid before accept", int'(m_axis_tvalid), 1);
    @(posedge clk);
    #1;
    chk("ovr tvalid after accept", int'(m_axis_tvalid), 0);
    chk("ovr accepted count", got_q.size(), 1);
    if (got_q.size() > 0) chk("ovr accepted word", int'(got_q[0]), 'h22);
    got_q.delete();

    // Reset in the middle of data bit 4 of 0xF0.
    fe0 = fe_cnt;
    fork
      send_frame(1, 8'hF0, 1'b1, 1'b0, 1'b0);
      begin
        repeat (8 * 5 + 4) @(posedge clk);
        #2;
        chk("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(8);
    chk("post reset busy", int'(busy), 0);
    chk("post reset words", got_q.size(), 0);
    chk("post reset ferr", fe_cnt - fe0, 0);
    got_q.delete();
    send_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0);
    idle(8);
    check_words("after reset");

    // 16 back-to-back frames at prescale 3.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 16; i++) send_frame(3, 8'(i), 1'b1, 1'b1, 1'b0);
    idle(24);
    check_words("burst");
    chk("burst ferr", fe_cnt - fe0, 0);
    chk("burst ovr", ov_cnt - ov0, 0);

    // Randomized frames, random gaps, random tready, prescale disturbed mid-frame.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    nbad = 0;
    got_q.delete();
    exp_q.delete();
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          int p;
          logic [W-1:0] d;
          bit ok;
          p = $urandom_range(1, 3);
          d = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          send_frame(p, d, ok, 1'b1, 1'b1);
          if (!ok) begin
            nbad++;
            idle(16 * p + $urandom_range(0, 8));
          end else begin
            idle($urandom_range(0, 12));
          end
        end
        idle(20);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tready = 1'b1;
    idle(10);
    check_words("random");
    chk("random ferr", fe_cnt - fe0, nbad);
    chk("random ovr", ov_cnt - ov0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
